st7789_seq: RTL and testbench
=============================

ST7789_SEQ -- requirements
Module: st7789_seq

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter MS_TICKS, default CLK_HZ/1000, clocks per millisecond delay tick; benches override it to a small value.
REQ-003 Parameter NPIX, default 57600, pixels per frame (240x240).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 lcd_rst  out  1  panel hardware reset, active-low.
REQ-007 tx_byte  out  8  byte offered to the SPI byte shifter.
REQ-008 tx_dc  out  1  0 = command byte, 1 = data byte; qualifies tx_byte.
REQ-009 tx_valid  out  1  tx_byte/tx_dc are valid.
REQ-010 tx_ready  in  1  shifter accepts the byte this cycle.
REQ-011 frame_start  in  1  one-cycle request to write a full frame.
REQ-012 pix_data  in  16  RGB565 pixel.
REQ-013 pix_valid  in  1  pix_data is valid.
REQ-014 pix_ready  out  1  pixel consumed this cycle.
REQ-015 init_done  out  1  init sequence complete; level, stays 1 until reset.
REQ-016 busy  out  1  frame write in progress.
REQ-017 frame_done  out  1  one-cycle pulse after the last pixel byte is accepted.

Function
REQ-018 Byte handshake: a byte transfers when tx_valid and tx_ready are both 1; tx_byte/tx_dc stay stable while tx_valid=1 and tx_ready=0; tx_valid never drops before transfer.
REQ-019 States: RST_LO, RST_WAIT, ROM_FETCH, ROM_SEND, DELAY, IDLE, WIN_SEND, PIX_FETCH, PIX_HI, PIX_LO, DONE.
REQ-020 RST_LO: lcd_rst=0 for 10 ms, then RST_WAIT: lcd_rst=1 for 120 ms, then ROM_FETCH at index 0.
REQ-021 Init ROM entries, in order: CMD 0x01, DELAY 150; CMD 0x11, DELAY 120; CMD 0x3A, DATA 0x55; CMD 0x36, DATA 0x00; CMD 0x21; CMD 0x13; CMD 0x29, DELAY 10; END.
REQ-022 CMD sends the byte with tx_dc=0 and DATA with tx_dc=1; DELAY n waits n*MS_TICKS cycles with tx_valid=0; END enters IDLE and sets init_done.
REQ-023 Millisecond delay counter and ms counter are wide enough for 150 ms at CLK_HZ; no wrap mid-delay.
REQ-024 In IDLE, frame_start=1 sets busy the next cycle and sends window bytes: 0x2A(c), 0x00,0x00,0x00,0xEF(d), 0x2B(c), 0x00,0x00,0x00,0xEF(d), 0x2C(c).
REQ-025 PIX_FETCH: pix_ready = pix_valid; on accept latch pix_data, go to PIX_HI (sends [15:8], dc=1), then PIX_LO (sends [7:0], dc=1).
REQ-026 Pixel counter counts accepted pixels 0..NPIX-1; after the PIX_LO transfer of pixel NPIX-1 enter DONE: frame_done=1 for one cycle, busy=0, return to IDLE.
REQ-027 pix_ready is 0 in every state other than PIX_FETCH.
REQ-028 frame_start outside IDLE (including before init_done) is ignored, not queued.
REQ-029 frame_start in the DONE cycle is ignored; a new frame needs frame_start in IDLE.
REQ-030 Pixel stall (pix_valid=0) holds PIX_FETCH indefinitely with tx_valid=0.

Reset
REQ-031 While rst=1: state RST_LO, lcd_rst=0, tx_valid=0, tx_byte=0x00, tx_dc=0, pix_ready=0, init_done=0, busy=0, frame_done=0, all counters 0.
REQ-032 Reset at any point, including mid-byte or mid-frame, abandons the operation; after release the full sequence restarts at REQ-020.

Structure
REQ-033 Command opcodes (0x01,0x11,0x3A,0x36,0x21,0x13,0x29,0x2A,0x2B,0x2C), ROM entry kind encoding (CMD, DATA, DELAY, END) and state encodings live in shared include st7789_defs.vh.
REQ-034 Init table is one combinational sub-module st7789_init_rom: index in, {kind, value} out; sequencer FSM, delay timer and pixel counter stay in st7789_seq.

Verification (MS_TICKS=4, NPIX=4, shifter model with tx_ready random 50%)
REQ-035 Release rst -> lcd_rst=0 for 40 cycles, 1 for 480 cycles, then first transfer 0x01 dc=0.
REQ-036 Run init -> captured byte stream 01c,11c,3Ac,55d,36c,00d,21c,13c,29c; gap after 01 >= 600 cycles, after 11 >= 480; init_done rises after last delay.
REQ-037 frame_start after init, pixels 0xF800,0x07E0,0x001F,0xFFFF -> 2A,00,00,00,EF,2B,00,00,00,EF,2C then F8,00,07,E0,00,1F,FF,FF all dc=1; one frame_done pulse.
REQ-038 tx_ready held 0 for 20 cycles mid-byte -> tx_byte/tx_dc unchanged, tx_valid stays 1.
REQ-039 frame_start during init and during busy -> no extra bytes, no second frame_done.
REQ-040 rst pulse after 2 pixels sent -> all outputs at REQ-031 values, busy=0, lcd_rst sequence restarts.

Source files
------------

// File: rtl/st7789_seq_pkg.sv
// Shared definitions for the ST7789 init/frame sequencer: opcodes, ROM entry
// format, FSM state encoding and the fixed 240x240 address-window byte list.
package st7789_seq_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;
  localparam logic [7:0] OP_MADCTL  = 8'h36;
  localparam logic [7:0] OP_INVON   = 8'h21;
  localparam logic [7:0] OP_NORON   = 8'h13;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  localparam logic [7:0] RST_LO_MS   = 8'd10;
  localparam logic [7:0] RST_WAIT_MS = 8'd120;
  localparam logic [3:0] WIN_LAST    = 4'd10;

  typedef enum logic [1:0] {
    KIND_CMD,
    KIND_DATA,
    KIND_DELAY,
    KIND_END
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [7:0] value;
  } rom_entry_t;

  typedef enum logic [3:0] {
    RST_LO,
    RST_WAIT,
    ROM_FETCH,
    ROM_SEND,
    DELAY,
    IDLE,
    WIN_SEND,
    PIX_FETCH,
    PIX_HI,
    PIX_LO,
    DONE
  } state_t;

  // Returns {dc, byte} for window byte idx: CASET 0..239, RASET 0..239, RAMWR.
  function automatic logic [8:0] win_entry(input logic [3:0] idx);
    logic [8:0] w;
    case (idx)
      4'd0:                w = {1'b0, OP_CASET};
      4'd1, 4'd2, 4'd3:    w = {1'b1, 8'h00};
      4'd4:                w = {1'b1, 8'hEF};
      4'd5:                w = {1'b0, OP_RASET};
      4'd6, 4'd7, 4'd8:    w = {1'b1, 8'h00};
      4'd9:                w = {1'b1, 8'hEF};
      default:             w = {1'b0, OP_RAMWR};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/st7789_init_rom.sv
// Combinational panel init table: one {kind, value} entry per index.
module st7789_init_rom
  import st7789_seq_pkg::*;
(
  input  logic [3:0]  idx,
  output rom_entry_t  entry
);

  always_comb begin
    entry = '{kind: KIND_END, value: 8'h00};
    case (idx)
      4'd0:  entry = '{kind: KIND_CMD,   value: OP_SWRESET};
      4'd1:  entry = '{kind: KIND_DELAY, value: 8'd150};
      4'd2:  entry = '{kind: KIND_CMD,   value: OP_SLPOUT};
      4'd3:  entry = '{kind: KIND_DELAY, value: 8'd120};
      4'd4:  entry = '{kind: KIND_CMD,   value: OP_COLMOD};
      4'd5:  entry = '{kind: KIND_DATA,  value: 8'h55};
      4'd6:  entry = '{kind: KIND_CMD,   value: OP_MADCTL};
      4'd7:  entry = '{kind: KIND_DATA,  value: 8'h00};
      4'd8:  entry = '{kind: KIND_CMD,   value: OP_INVON};
      4'd9:  entry = '{kind: KIND_CMD,   value: OP_NORON};
      4'd10: entry = '{kind: KIND_CMD,   value: OP_DISPON};
      4'd11: entry = '{kind: KIND_DELAY, value: 8'd10};
      default: entry = '{kind: KIND_END, value: 8'h00};
    endcase
  end

endmodule

// File: rtl/st7789_seq.sv
// ST7789 sequencer: hardware reset, ROM-driven init, then 240x240 RGB565 frame
// writes onto a byte stream (valid/ready handshake towards the SPI shifter).
module st7789_seq
  import st7789_seq_pkg::*;
#(
  parameter int CLK_HZ   = 27000000,
  parameter int MS_TICKS = CLK_HZ / 1000,
  parameter int NPIX     = 57600
) (
  input  logic        clk,
  input  logic        rst,
  output logic        lcd_rst,
  output logic [7:0]  tx_byte,
  output logic        tx_dc,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        frame_start,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        init_done,
  output logic        busy,
  output logic        frame_done,
  output state_t      state
);

  // Handshake: a byte moves when tx_valid && tx_ready; while tx_valid=1 the
  // byte and dc are held until that happens, and tx_valid never drops early.
  localparam int TW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(MS_TICKS - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);

  logic [TW-1:0] tick_cnt;
  logic [7:0]    ms_cnt;
  logic [7:0]    ms_target;
  logic [3:0]    rom_idx;
  logic [3:0]    win_idx;
  logic [PW-1:0] pix_cnt;
  logic [15:0]   pix_lat;
  rom_entry_t    rom_entry;
  logic          tmr_done;
  logic          tx_fire;

  st7789_init_rom u_rom (
    .idx   (rom_idx),
    .entry (rom_entry)
  );

  assign tmr_done  = (tick_cnt == TICK_LAST) && (ms_cnt == ms_target - 8'd1);
  assign tx_fire   = tx_valid && tx_ready;
  assign pix_ready = (state == PIX_FETCH) && pix_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RST_LO;
      lcd_rst    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_byte    <= 8'h00;
      tx_dc      <= 1'b0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tick_cnt   <= '0;
      ms_cnt     <= '0;
      ms_target  <= RST_LO_MS;
      rom_idx    <= '0;
      win_idx    <= '0;
      pix_cnt    <= '0;
      pix_lat    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        RST_LO, RST_WAIT, DELAY: begin
          // Shared ms timer: ms_target milliseconds of MS_TICKS clocks each.
          if (tmr_done) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
            if (state == RST_LO) begin
              lcd_rst   <= 1'b1;
              ms_target <= RST_WAIT_MS;
              state     <= RST_WAIT;
            end else if (state == RST_WAIT) begin
              rom_idx <= '0;
              state   <= ROM_FETCH;
            end else begin
              rom_idx <= rom_idx + 4'd1;
              state   <= ROM_FETCH;
            end
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            ms_cnt   <= ms_cnt + 8'd1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        ROM_FETCH: begin
          case (rom_entry.kind)
            KIND_CMD, KIND_DATA: begin
              tx_byte  <= rom_entry.value;
              tx_dc    <= (rom_entry.kind == KIND_DATA);
              tx_valid <= 1'b1;
              state    <= ROM_SEND;
            end
            KIND_DELAY: begin
              ms_target <= rom_entry.value;
              state     <= DELAY;
            end
            default: begin
              init_done <= 1'b1;
              state     <= IDLE;
            end
          endcase
        end
        ROM_SEND: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            rom_idx  <= rom_idx + 4'd1;
            state    <= ROM_FETCH;
          end
        end
        IDLE: begin
          if (frame_start) begin
            busy              <= 1'b1;
            win_idx           <= 4'd0;
            {tx_dc, tx_byte}  <= win_entry(4'd0);
            tx_valid          <= 1'b1;
            state             <= WIN_SEND;
          end
        end
        WIN_SEND: begin
          if (tx_fire) begin
            if (win_idx == WIN_LAST) begin
              tx_valid <= 1'b0;
              pix_cnt  <= '0;
              state    <= PIX_FETCH;
            end else begin
              win_idx          <= win_idx + 4'd1;
              {tx_dc, tx_byte} <= win_entry(win_idx + 4'd1);
            end
          end
        end
        PIX_FETCH: begin
          if (pix_valid) begin
            pix_lat  <= pix_data;
            tx_byte  <= pix_data[15:8];
            tx_dc    <= 1'b1;
            tx_valid <= 1'b1;
            state    <= PIX_HI;
          end
        end
        PIX_HI: begin
          if (tx_fire) begin
            tx_byte <= pix_lat[7:0];
            state   <= PIX_LO;
          end
        end
        PIX_LO: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            if (pix_cnt == PIX_LAST) begin
              pix_cnt    <= '0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end else begin
              pix_cnt <= pix_cnt + PW'(1);
              state   <= PIX_FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= RST_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st7789_seq.sv
// Bench for st7789_seq: random-ready shifter, random-gap pixel source, and a
// byte scoreboard fed from a spec-level model of the init and frame streams.
module tb_st7789_seq;
  import st7789_seq_pkg::*;

  localparam int MS_TICKS = 4;
  localparam int NPIX     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lcd_rst;
  logic [7:0]  tx_byte;
  logic        tx_dc;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        init_done;
  logic        busy;
  logic        frame_done;
  state_t      dbg_state;

  st7789_seq #(.CLK_HZ(27000000), .MS_TICKS(MS_TICKS), .NPIX(NPIX)) dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_rst     (lcd_rst),
    .tx_byte     (tx_byte),
    .tx_dc       (tx_dc),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .frame_start (frame_start),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .init_done   (init_done),
    .busy        (busy),
    .frame_done  (frame_done),
    .state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  logic [8:0] init_ref [9] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036,
                               9'h100, 9'h021, 9'h013, 9'h029};
  logic [8:0] win_ref [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
                               9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C};

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] pix_q[$];
  int          xfer_t[$];
  int          n_xfer = 0;
  int          done_seen = 0;
  int          exp_frames = 0;
  bit          hold_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [8:0]  prev_word = '0;
  logic [8:0]  mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- shifter / pixel driver + monitor ----------------
  always @(negedge clk) begin
    tx_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
    if (pix_q.size() > 0 && $urandom_range(0, 99) < 70) begin
      pix_valid = 1'b1;
      pix_data  = pix_q[0];
    end else begin
      pix_valid = 1'b0;
      pix_data  = 16'($urandom);
    end
    #1;
    if (!rst) begin
      if (prev_stall) begin
        checks++;
        if (!tx_valid || {tx_dc, tx_byte} !== prev_word) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b word=%0h expected valid=1 word=%0h",
                   tx_valid, {tx_dc, tx_byte}, prev_word);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_word  = {tx_dc, tx_byte};
      if (tx_valid && tx_ready) begin
        xfer_t.push_back(cyc);
        n_xfer++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_stream: got unexpected dc/byte %0h expected none", {tx_dc, tx_byte});
        end else begin
          mon_w = exp_q.pop_front();
          if (mon_w !== {tx_dc, tx_byte}) begin
            errors++;
            $display("FAIL byte_stream: got dc/byte %0h expected %0h", {tx_dc, tx_byte}, mon_w);
          end
        end
      end
      checks++;
      if (pix_ready && !pix_valid) begin
        errors++;
        $display("FAIL pix_ready_qual: got pix_ready=1 expected 0 with pix_valid=0");
      end
      if (pix_valid && pix_ready) void'(pix_q.pop_front());
      if (frame_done) done_seen++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_lcd_rst"},    32'(lcd_rst), 32'd0);
    check({tag, "_tx_valid"},   32'(tx_valid), 32'd0);
    check({tag, "_tx_byte"},    32'(tx_byte), 32'h00);
    check({tag, "_tx_dc"},      32'(tx_dc), 32'd0);
    check({tag, "_pix_ready"},  32'(pix_ready), 32'd0);
    check({tag, "_init_done"},  32'(init_done), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_state"},      32'(dbg_state), 32'(RST_LO));
  endtask

  task automatic release_reset();
    int lo;
    int hi;
    @(negedge clk);
    exp_q.delete();
    pix_q.delete();
    xfer_t.delete();
    foreach (init_ref[i]) exp_q.push_back(init_ref[i]);
    rst = 1'b0;
    lo = 0;
    while (lcd_rst === 1'b0 && lo < 2000) begin
      lo++;
      @(negedge clk);
    end
    check("lcd_rst_low_cycles", 32'(lo), 32'd40);
    hi = 0;
    while (!tx_valid && hi < 2000) begin
      hi++;
      @(negedge clk);
    end
    check_range("lcd_rst_high_cycles", hi, 480, 484);
    check("first_byte", 32'({tx_dc, tx_byte}), 32'h001);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 6000) begin
      n++;
      @(negedge clk);
    end
    check("init_done_rise", 32'(init_done), 32'd1);
    #2;
    check("init_stream_drained", 32'(exp_q.size()), 32'd0);
    if (xfer_t.size() >= 9) begin
      check_range("gap_after_01", xfer_t[1] - xfer_t[0], 600, 100000);
      check_range("gap_after_11", xfer_t[2] - xfer_t[1], 480, 100000);
      check_range("init_done_after_delay", cyc - xfer_t[8], 40, 100000);
    end else begin
      check("init_xfer_count", 32'(xfer_t.size()), 32'd9);
    end
  endtask

  task automatic start_frame(input logic [15:0] px [NPIX]);
    foreach (win_ref[i]) exp_q.push_back(win_ref[i]);
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back({1'b1, px[i][15:8]});
      exp_q.push_back({1'b1, px[i][7:0]});
      pix_q.push_back(px[i]);
    end
    exp_frames++;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic pulse_frame_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (done_seen < exp_frames && n < 4000) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #2;
    check("frame_done_count", 32'(done_seen), 32'(exp_frames));
    check("busy_after_frame", 32'(busy), 32'd0);
    check("frame_stream_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] px [NPIX];
  logic [8:0]  held_word;
  int          base;
  int          saved_done;

  initial begin
    rst = 1'b1;
    pix_q.push_back(16'hA5A5);
    repeat (4) @(negedge clk);
    #2;
    check_reset_outputs("reset");

    release_reset();
    repeat (200) @(negedge clk);
    pulse_frame_start();
    wait_init();
    check("busy_after_init", 32'(busy), 32'd0);

    // Directed frame with a 20-cycle shifter stall and a frame_start while busy.
    px = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    start_frame(px);
    hold_ready = 1'b1;
    @(negedge clk);
    #2;
    held_word = {tx_dc, tx_byte};
    repeat (20) @(negedge clk);
    #2;
    check("stall_valid", 32'(tx_valid), 32'd1);
    check("stall_word", 32'({tx_dc, tx_byte}), 32'(held_word));
    hold_ready = 1'b0;
    pulse_frame_start();
    wait_frame();

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) px[i] = 16'($urandom);
      start_frame(px);
      wait_frame();
    end

    // Reset after two pixels have gone out.
    for (int i = 0; i < NPIX; i++) px[i] = 16'($urandom);
    base = n_xfer;
    start_frame(px);
    begin
      int n;
      n = 0;
      while (n_xfer < base + 15 && n < 4000) begin
        n++;
        @(negedge clk);
      end
      check("midframe_bytes_sent", 32'(n_xfer - base), 32'd15);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_frames--;
    saved_done = done_seen;
    #2;
    check_reset_outputs("midframe_reset");
    repeat (3) @(negedge clk);
    release_reset();
    wait_init();
    check("no_frame_done_after_reset", 32'(done_seen), 32'(saved_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
